// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity support is enabled with the UART_RX_PARITY_EN macro.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        CLEANUP
    } rx_state_t;

    // Mid-bit offset used to centre the start-bit sample.
    function automatic int unsigned half_bit(input int unsigned cy_per_bit);
        return (cy_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial line and received-byte signals between the UART line and the receiver.
// The o_Rx_Parity_Err signal exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic                 i_Rx_Serial;
    logic                 o_Rx_Dv;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_Frame_Err;
    logic                 o_Rx_Busy;
`ifdef UART_RX_PARITY_EN
    logic                 o_Rx_Parity_Err;
`endif

    modport master (
        output i_Rx_Serial,
        input  o_Rx_Dv,
        input  o_Rx_Byte,
        input  o_Rx_Frame_Err,
`ifdef UART_RX_PARITY_EN
        input  o_Rx_Parity_Err,
`endif
        input  o_Rx_Busy
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_Dv,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
`ifdef UART_RX_PARITY_EN
        output o_Rx_Parity_Err,
`endif
        output o_Rx_Busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to idle-high.
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with start-glitch rejection, stop-bit framing check and busy flag.
// Defining UART_RX_PARITY_EN switches to 8E1 and adds o_Rx_Parity_Err.
`timescale 1ns/1ps
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_CY_PER_BIT = 87,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_rx_frame_if.slave rx
);

    localparam int unsigned CW = $clog2(CLK_CY_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_CY_PER_BIT - 1);
    // START leaves on the HALF-th counting cycle; the IDLE detect cycle supplies the extra one.
    localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLK_CY_PER_BIT) - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] byte_q, byte_n;
    logic                 dv_q, dv_n;
    logic                 ferr_q, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_n;
    logic                 perr_q, perr_n;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .rx   (rx.i_Rx_Serial),
        .rx_s (rx_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            byte_q <= '0;
            dv_q   <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q  <= 1'b0;
            perr_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            byte_q <= byte_n;
            dv_q   <= dv_n;
            ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q  <= par_n;
            perr_q <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        byte_n  = byte_q;
        dv_n    = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n        = '0;
                    shreg_n[idx] = rx_s;
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = CLEANUP;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg, par_q}) begin
                            perr_n = 1'b1;
                        end else begin
                            byte_n = shreg;
                            dv_n   = 1'b1;
                        end
`else
                        byte_n  = shreg;
                        dv_n    = 1'b1;
`endif
                    end else begin
                        state_n = BREAK;
                        ferr_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_n  = ^{shreg, par_q};
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = CLEANUP;
                end
            end
            CLEANUP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx.o_Rx_Dv        = dv_q;
    assign rx.o_Rx_Byte      = byte_q;
    assign rx.o_Rx_Frame_Err = ferr_q;
    assign rx.o_Rx_Busy      = (state != IDLE) && (state != CLEANUP);
`ifdef UART_RX_PARITY_EN
    assign rx.o_Rx_Parity_Err = perr_q;
`endif

endmodule
